// File: rtl/sseg_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : sseg_decoder
//  Description : Snoops a multiplexed 7-segment bus. It filters each
//                {seg,an} pattern for stability and decodes the pattern back
//                to a hex nibble. It keeps a per-digit register file of
//                value/dp/vld/err and pulses upd when a digit's stored
//                contents change.
//  Revision    : 1.0 - initial release
// ============================================================================
module sseg_decoder #(
  parameter  int DIGITS = 4,
  parameter  int STABLE = 8,
  localparam int IW     = (DIGITS > 1) ? $clog2(DIGITS) : 1,
  localparam int CW     = $clog2(STABLE + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          seg,
  input  logic [DIGITS-1:0]   an,
  output logic [4*DIGITS-1:0] value,
  output logic [DIGITS-1:0]   dp,
  output logic [DIGITS-1:0]   vld,
  output logic [DIGITS-1:0]   err,
  output logic                upd,
  output logic [IW-1:0]       upd_idx
);

  localparam logic [CW-1:0] C_STABLE = CW'(STABLE);

  // Returns {valid, nibble} for a 7-bit segment pattern (g..a)
  function automatic logic [4:0] decode(input logic [6:0] p);
    logic [4:0] r;
    case (p)
      7'h3F:   r = 5'h10;
      7'h06:   r = 5'h11;
      7'h5B:   r = 5'h12;
      7'h4F:   r = 5'h13;
      7'h66:   r = 5'h14;
      7'h6D:   r = 5'h15;
      7'h7D:   r = 5'h16;
      7'h07:   r = 5'h17;
      7'h7F:   r = 5'h18;
      7'h6F:   r = 5'h19;
      7'h77:   r = 5'h1A;
      7'h7C:   r = 5'h1B;
      7'h58:   r = 5'h1C;
      7'h5E:   r = 5'h1D;
      7'h79:   r = 5'h1E;
      7'h71:   r = 5'h1F;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  logic [7:0]          s_seg_q, s_seg_d;
  logic [DIGITS-1:0]   s_an_q, s_an_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                armed_q, armed_d;
  logic [4*DIGITS-1:0] value_q, value_d;
  logic [DIGITS-1:0]   dp_q, dp_d;
  logic [DIGITS-1:0]   vld_q, vld_d;
  logic [DIGITS-1:0]   err_q, err_d;
  logic                upd_q, upd_d;
  logic [IW-1:0]       upd_idx_q, upd_idx_d;

  logic                same;
  logic                onehot;
  logic                capture;
  logic                changed;
  logic [IW-1:0]       idx;
  logic [4:0]          dec;

  // Filter, capture and register-file next-state logic
  always_comb begin
    s_seg_d   = seg;
    s_an_d    = an;
    cnt_d     = cnt_q;
    armed_d   = armed_q;
    value_d   = value_q;
    dp_d      = dp_q;
    vld_d     = vld_q;
    err_d     = err_q;
    upd_d     = 1'b0;
    upd_idx_d = upd_idx_q;
    changed   = 1'b0;
    idx       = '0;

    same   = (seg == s_seg_q) && (an == s_an_q);
    onehot = (an != '0) && ((an & (an - 1'b1)) == '0);
    dec    = decode(seg[6:0]);

    for (int i = 0; i < DIGITS; i++) begin
      if (an[i]) idx = IW'(i);
    end

    // The count is complete on the capture edge. Requiring an unchanged input
    // as well stops a pattern that glitches on that edge from being latched.
    capture = onehot && same && armed_q && (cnt_q == C_STABLE);

    if (!onehot) begin
      cnt_d   = '0;
      armed_d = 1'b1;
    end else if (!same) begin
      cnt_d   = CW'(1);
      armed_d = 1'b1;
    end else if (cnt_q < C_STABLE) begin
      cnt_d = cnt_q + 1'b1;
    end

    if (capture) begin
      armed_d = 1'b0;
      if (dec[4]) begin
        value_d[int'(idx)*4 +: 4] = dec[3:0];
      end
      dp_d[idx]  = seg[7];
      vld_d[idx] = dec[4];
      err_d[idx] = ~dec[4];
      changed = (value_d[int'(idx)*4 +: 4] != value_q[int'(idx)*4 +: 4]) ||
                (dp_d[idx]  != dp_q[idx])  ||
                (vld_d[idx] != vld_q[idx]) ||
                (err_d[idx] != err_q[idx]);
      if (changed) begin
        upd_d     = 1'b1;
        upd_idx_d = idx;
      end
    end
  end

  // State registers; reset wins over a capture on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      s_seg_q   <= '0;
      s_an_q    <= '0;
      cnt_q     <= '0;
      armed_q   <= 1'b1;
      value_q   <= '0;
      dp_q      <= '0;
      vld_q     <= '0;
      err_q     <= '0;
      upd_q     <= 1'b0;
      upd_idx_q <= '0;
    end else begin
      s_seg_q   <= s_seg_d;
      s_an_q    <= s_an_d;
      cnt_q     <= cnt_d;
      armed_q   <= armed_d;
      value_q   <= value_d;
      dp_q      <= dp_d;
      vld_q     <= vld_d;
      err_q     <= err_d;
      upd_q     <= upd_d;
      upd_idx_q <= upd_idx_d;
    end
  end

  assign value   = value_q;
  assign dp      = dp_q;
  assign vld     = vld_q;
  assign err     = err_q;
  assign upd     = upd_q;
  assign upd_idx = upd_idx_q;

endmodule
`default_nettype wire
